// File: rtl/display_pkg.sv
// display_pkg: shared register addresses, FSM encoding and digit frame builder for the display scheduler
package display_pkg;
  localparam int NUM_DIGITS = 6;
  localparam logic [3:0] REG_DECODE    = 4'h9;
  localparam logic [3:0] REG_INTENSITY = 4'hA;
  localparam logic [3:0] REG_SCANLIMIT = 4'hB;
  localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
  localparam logic [3:0] REG_TEST      = 4'hF;
  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_UPDATE} state_e;
  function automatic logic [15:0] digit_frame(input logic [2:0] i, input logic [23:0] s, input logic [5:0] dp);
    return {4'h0, 1'b0, i + 3'd1, dp[i], 3'b000, s[{i, 2'b00} +: 4]};
  endfunction
endpackage

// File: rtl/display_init_rom.sv
// display_init_rom: maps an init index (0..5) to its controller initialisation frame; idx_i in, frame_o out
module display_init_rom
  import display_pkg::*;
#(
  parameter logic [3:0] INTENSITY = 4'h8
) (
  input  logic [2:0]  idx_i,
  output logic [15:0] frame_o
);
  assign frame_o = idx_i == 3'd0 ? {4'h0, REG_SHUTDOWN, 8'h00} :
                   idx_i == 3'd1 ? {4'h0, REG_TEST, 8'h00} :
                   idx_i == 3'd2 ? {4'h0, REG_SCANLIMIT, 8'h05} :
                   idx_i == 3'd3 ? {4'h0, REG_DECODE, 8'hFF} :
                   idx_i == 3'd4 ? {4'h0, REG_INTENSITY, 4'h0, INTENSITY} :
                   idx_i == 3'd5 ? {4'h0, REG_SHUTDOWN, 8'h01} : 16'h0000;
endmodule

// File: rtl/display_frame_scheduler.sv
// display_frame_scheduler: issues init frames after reset, then one digit-write burst per refresh tick; clk/res, ena/tick, digit inputs, frame valid/data/ready handshake, busy, init_done
module display_frame_scheduler
  import display_pkg::*;
#(
  parameter logic [3:0] INTENSITY = 4'h8,
  parameter logic [5:0] DP_MASK   = 6'b010100
) (
  input  logic        clk,
  input  logic        res,
  input  logic        ena,
  input  logic        tick,
  input  logic [2:0]  min_X0,
  input  logic [3:0]  min_0X,
  input  logic [2:0]  sec_X0,
  input  logic [3:0]  sec_0X,
  input  logic [3:0]  ces_X0,
  input  logic [3:0]  ces_0X,
  output logic        frame_valid,
  output logic [15:0] frame_data,
  input  logic        frame_ready,
  output logic        busy,
  output logic        init_done
);
  state_e      state_q;
  logic [2:0]  idx_q;
  logic        pending_q;
  logic [23:0] snap_q;
  logic        valid_q;
  logic [15:0] data_q;
  logic        busy_q;
  logic        done_q;
  logic [23:0] snap_d;
  logic [2:0]  rom_idx;
  logic [15:0] rom_frame;
  logic        xfer;
  logic        last;
  assign snap_d = {1'b0, min_X0, min_0X, 1'b0, sec_X0, sec_0X, ces_X0, ces_0X};
  assign xfer = valid_q && frame_ready;
  assign last = idx_q == 3'(NUM_DIGITS - 1);
  // Before the first init frame is presented the ROM must supply frame 0, afterwards the next one.
  assign rom_idx = valid_q ? idx_q + 3'd1 : 3'd0;
  display_init_rom #(.INTENSITY(INTENSITY)) u_rom (
    .idx_i  (rom_idx),
    .frame_o(rom_frame)
  );
  always_ff @(posedge clk) begin
    if (res) begin
      state_q   <= ST_INIT;
      idx_q     <= 3'd0;
      pending_q <= 1'b0;
      snap_q    <= 24'h0;
      valid_q   <= 1'b0;
      data_q    <= 16'h0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (tick) pending_q <= 1'b1;
          if (!valid_q) begin
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            data_q  <= rom_frame;
          end else if (xfer) begin
            if (last) begin
              state_q <= ST_IDLE;
              idx_q   <= 3'd0;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q  <= idx_q + 3'd1;
              data_q <= rom_frame;
            end
          end
        end
        ST_IDLE: begin
          if (ena && (tick || pending_q)) begin
            snap_q    <= snap_d;
            pending_q <= 1'b0;
            state_q   <= ST_UPDATE;
            valid_q   <= 1'b1;
            busy_q    <= 1'b1;
            data_q    <= digit_frame(3'd0, snap_d, DP_MASK);
          end else if (tick) pending_q <= 1'b1;
        end
        ST_UPDATE: begin
          if (tick) pending_q <= 1'b1;
          if (xfer) begin
            if (last) begin
              state_q <= ST_IDLE;
              idx_q   <= 3'd0;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
            end else begin
              idx_q  <= idx_q + 3'd1;
              data_q <= digit_frame(idx_q + 3'd1, snap_q, DP_MASK);
            end
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end
  assign frame_valid = valid_q;
  assign frame_data  = data_q;
  assign busy        = busy_q;
  assign init_done   = done_q;
endmodule

// File: tb/tb_display_frame_scheduler.sv
// tb_display_frame_scheduler: directed-vector self-checking bench for display_frame_scheduler
module tb_display_frame_scheduler;
  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        ena = 1'b0;
  logic        tick = 1'b0;
  logic [2:0]  min_X0 = '0;
  logic [3:0]  min_0X = '0;
  logic [2:0]  sec_X0 = '0;
  logic [3:0]  sec_0X = '0;
  logic [3:0]  ces_X0 = '0;
  logic [3:0]  ces_0X = '0;
  logic        frame_valid;
  logic [15:0] frame_data;
  logic        frame_ready = 1'b1;
  logic        busy;
  logic        init_done;
  int checks = 0;
  int errors = 0;
  localparam logic [95:0] INIT_F = {16'h0C00, 16'h0F00, 16'h0B05, 16'h09FF, 16'h0A08, 16'h0C01};
  localparam logic [95:0] F1 = {16'h0102, 16'h0204, 16'h0387, 16'h0403, 16'h0589, 16'h0605};
  localparam logic [95:0] F2 = {16'h0109, 16'h0209, 16'h0389, 16'h0405, 16'h0580, 16'h0601};
  localparam logic [95:0] F3 = {16'h010C, 16'h020F, 16'h038A, 16'h0407, 16'h058B, 16'h0607};
  display_frame_scheduler dut (
    .clk(clk), .res(res), .ena(ena), .tick(tick),
    .min_X0(min_X0), .min_0X(min_0X), .sec_X0(sec_X0), .sec_0X(sec_0X),
    .ces_X0(ces_X0), .ces_0X(ces_0X),
    .frame_valid(frame_valid), .frame_data(frame_data), .frame_ready(frame_ready),
    .busy(busy), .init_done(init_done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic set_digits(input logic [23:0] d);
    min_X0 = d[22:20];
    min_0X = d[19:16];
    sec_X0 = d[14:12];
    sec_0X = d[11:8];
    ces_X0 = d[7:4];
    ces_0X = d[3:0];
  endtask
  task automatic chk_reset(input string tag);
    check({tag, ".valid"}, 16'(frame_valid), 16'h0);
    check({tag, ".data"}, frame_data, 16'h0);
    check({tag, ".busy"}, 16'(busy), 16'h0);
    check({tag, ".done"}, 16'(init_done), 16'h0);
  endtask
  task automatic hook(input int u, input int k);
    if (u == 1 && k == 2) set_digits(24'h105999);
    if (u == 2 && (k == 1 || k == 3)) tick = 1'b1;
    if (u == 2 && (k == 2 || k == 4)) tick = 1'b0;
    if (u == 2 && k == 2) set_digits(24'h7B7AFC);
    if (u == 3 && k == 5) tick = 1'b1;
    if (u == 4 && k == 2) ena = 1'b0;
  endtask
  task automatic upd(input string tag, input int u, input logic [95:0] fr, input int n);
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s.valid%0d", tag, k), 16'(frame_valid), 16'h1);
      check($sformatf("%s.busy%0d", tag, k), 16'(busy), 16'h1);
      check($sformatf("%s.frame%0d", tag, k), frame_data, fr[95-16*k -: 16]);
      hook(u, k);
      step();
    end
  endtask
  initial begin
    set_digits(24'h593742);
    step();
    step();
    chk_reset("reset");
    res = 1'b0;
    step();
    for (int k = 0; k < 6; k++) begin
      check($sformatf("init.valid%0d", k), 16'(frame_valid), 16'h1);
      check($sformatf("init.busy%0d", k), 16'(busy), 16'h1);
      check($sformatf("init.frame%0d", k), frame_data, INIT_F[95-16*k -: 16]);
      check($sformatf("init.notdone%0d", k), 16'(init_done), 16'h0);
      if (k == 0) tick = 1'b1;
      if (k == 1) tick = 1'b0;
      if (k == 3) ena = 1'b1;
      if (k == 2) begin
        frame_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          step();
          check($sformatf("stall.valid%0d", s), 16'(frame_valid), 16'h1);
          check($sformatf("stall.frame%0d", s), frame_data, 16'h0B05);
        end
        frame_ready = 1'b1;
      end
      step();
    end
    check("init.done", 16'(init_done), 16'h1);
    check("init.idle_busy", 16'(busy), 16'h0);
    check("init.idle_valid", 16'(frame_valid), 16'h0);
    step();
    upd("upd1", 1, F1, 6);
    for (int s = 0; s < 3; s++) begin
      check($sformatf("upd1.no_repeat%0d", s), 16'(frame_valid), 16'h0);
      check($sformatf("upd1.idle_busy%0d", s), 16'(busy), 16'h0);
      step();
    end
    tick = 1'b1;
    step();
    tick = 1'b0;
    upd("upd2", 2, F2, 6);
    check("upd2.gap_valid", 16'(frame_valid), 16'h0);
    step();
    upd("upd3", 3, F3, 6);
    tick = 1'b0;
    check("upd3.gap_valid", 16'(frame_valid), 16'h0);
    check("upd3.gap_busy", 16'(busy), 16'h0);
    step();
    upd("upd4", 4, F3, 6);
    check("upd4.end_valid", 16'(frame_valid), 16'h0);
    tick = 1'b1;
    step();
    tick = 1'b0;
    for (int s = 0; s < 3; s++) begin
      check($sformatf("ena_low.valid%0d", s), 16'(frame_valid), 16'h0);
      step();
    end
    ena = 1'b1;
    step();
    upd("upd5", 5, F3, 3);
    check("upd5.frame3", frame_data, 16'h0407);
    res = 1'b1;
    step();
    chk_reset("midreset");
    res = 1'b0;
    step();
    check("rerun.valid", 16'(frame_valid), 16'h1);
    check("rerun.frame", frame_data, 16'h0C00);
    check("rerun.busy", 16'(busy), 16'h1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
